// File: rtl/sprite_line_scheduler_pkg.sv
// Shared constants and FSM encoding for the per-scanline sprite scheduler.
package sprite_line_scheduler_pkg;
  localparam int         OBJ_BYTES  = 4;
  localparam int         OFS_Y      = 1;
  localparam int         OFS_SIZE   = 3;
  localparam logic [7:0] DISABLED_Y = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    RD_Y,
    RD_S,
    EVAL,
    DONE
  } state_t;
endpackage

// File: rtl/sprite_line_scheduler_if.sv
// Control, object-table read port and slot result bundle of the sprite scheduler.
interface sprite_line_scheduler_if #(
  parameter int SLOTS = 4
);
  logic               enable;
  logic               frame_start;
  logic               line_start;
  logic [7:0]         next_y;
  logic [5:0]         obj_rd_addr;
  logic [7:0]         obj_rd_data;
  logic [SLOTS-1:0]   slot_valid;
  logic [4*SLOTS-1:0] slot_idx;
  logic [4*SLOTS-1:0] slot_row;
  logic               busy;
  logic               done;
  logic               overflow;
  logic               late;

  modport slave (
    input  enable, frame_start, line_start, next_y, obj_rd_data,
    output obj_rd_addr, slot_valid, slot_idx, slot_row, busy, done, overflow, late
  );

  modport master (
    output enable, frame_start, line_start, next_y, obj_rd_data,
    input  obj_rd_addr, slot_valid, slot_idx, slot_row, busy, done, overflow, late
  );
endinterface

// File: rtl/sprite_line_scheduler.sv
// Scans the object table during hblank and picks the first SLOTS sprites covering next_y.
module sprite_line_scheduler
  import sprite_line_scheduler_pkg::*;
#(
  parameter int MAX_SPRITES = 8,
  parameter int SLOTS       = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  sprite_line_scheduler_if.slave   bus
);
  localparam int CNT_W = $clog2(SLOTS + 1);

  state_t             state_q, state_d;
  logic [3:0]         spr_q, spr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         ny_q, ny_d;
  logic [7:0]         y_q, y_d;
  logic [4*SLOTS-1:0] sh_idx_q, sh_idx_d;
  logic [4*SLOTS-1:0] sh_row_q, sh_row_d;
  logic [SLOTS-1:0]   valid_q, valid_d;
  logic [4*SLOTS-1:0] idx_q, idx_d;
  logic [4*SLOTS-1:0] row_q, row_d;
  logic               ovf_q, ovf_d;
  logic               late_q, late_d;
  logic               restart, scan_active, last_spr, hit;
  logic               ovf_set, load_out;

  // Bottom edge is formed at 9 bits so a sprite near line 255 never wraps to the top.
  function automatic logic sprite_hit(input logic [7:0] y, input logic [3:0] size_lo,
                                      input logic [7:0] ny);
    logic [8:0] bottom;
    bottom = {1'b0, y} + {5'b0, size_lo} + 9'd1;
    return (y != DISABLED_Y) && (ny >= y) && ({1'b0, ny} < bottom);
  endfunction

  assign scan_active = (state_q == RD_Y) || (state_q == RD_S) || (state_q == EVAL);
  assign restart     = bus.enable && bus.line_start;
  assign last_spr    = 32'(spr_q) >= MAX_SPRITES - 1;
  assign hit         = sprite_hit(y_q, bus.obj_rd_data[3:0], ny_q);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!bus.enable)          state_d = IDLE;
    else if (bus.line_start)  state_d = RD_Y;
    else begin
      case (state_q)
        RD_Y:    state_d = RD_S;
        RD_S:    state_d = EVAL;
        EVAL:    state_d = last_spr ? DONE : RD_Y;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.obj_rd_addr = '0;
    bus.busy        = scan_active;
    bus.done        = (state_q == DONE);
    case (state_q)
      RD_Y:    bus.obj_rd_addr = 6'(32'(spr_q) * OBJ_BYTES + OFS_Y);
      RD_S:    bus.obj_rd_addr = 6'(32'(spr_q) * OBJ_BYTES + OFS_SIZE);
      default: bus.obj_rd_addr = '0;
    endcase
  end

  // A restart discards the partial shadow; visible slots only change on the EVAL->DONE edge.
  always_comb begin
    spr_d    = spr_q;
    cnt_d    = cnt_q;
    ny_d     = ny_q;
    y_d      = y_q;
    sh_idx_d = sh_idx_q;
    sh_row_d = sh_row_q;
    ovf_set  = 1'b0;
    if (restart) begin
      spr_d    = '0;
      cnt_d    = '0;
      ny_d     = bus.next_y;
      sh_idx_d = '0;
      sh_row_d = '0;
    end else if (bus.enable && state_q == RD_S) begin
      y_d = bus.obj_rd_data;
    end else if (bus.enable && state_q == EVAL) begin
      spr_d = spr_q + 4'd1;
      if (hit) begin
        if (32'(cnt_q) < SLOTS) begin
          sh_idx_d[4*cnt_q +: 4] = spr_q;
          sh_row_d[4*cnt_q +: 4] = 4'(ny_q - y_q);
          cnt_d                  = cnt_q + CNT_W'(1);
        end else begin
          ovf_set = 1'b1;
        end
      end
    end

    load_out = (state_q == EVAL) && (state_d == DONE);
    valid_d  = valid_q;
    idx_d    = idx_q;
    row_d    = row_q;
    if (load_out) begin
      valid_d = SLOTS'((32'd1 << cnt_d) - 32'd1);
      idx_d   = sh_idx_d;
      row_d   = sh_row_d;
    end

    ovf_d  = ovf_set ? 1'b1 : (bus.frame_start ? 1'b0 : ovf_q);
    late_d = (restart && scan_active) ? 1'b1 : (bus.frame_start ? 1'b0 : late_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      spr_q    <= '0;
      cnt_q    <= '0;
      ny_q     <= '0;
      y_q      <= '0;
      sh_idx_q <= '0;
      sh_row_q <= '0;
      valid_q  <= '0;
      idx_q    <= '0;
      row_q    <= '0;
      ovf_q    <= 1'b0;
      late_q   <= 1'b0;
    end else begin
      spr_q    <= spr_d;
      cnt_q    <= cnt_d;
      ny_q     <= ny_d;
      y_q      <= y_d;
      sh_idx_q <= sh_idx_d;
      sh_row_q <= sh_row_d;
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      row_q    <= row_d;
      ovf_q    <= ovf_d;
      late_q   <= late_d;
    end
  end

  assign bus.slot_valid = valid_q;
  assign bus.slot_idx   = idx_q;
  assign bus.slot_row   = row_q;
  assign bus.overflow   = ovf_q;
  assign bus.late       = late_q;
endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Randomized and directed bench for sprite_line_scheduler against a sprite-list reference model.
module tb_sprite_line_scheduler;
  localparam int NSPR = 8;
  localparam int NSL  = 4;
  localparam int LAT  = 3 * NSPR + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sprite_line_scheduler_if #(.SLOTS(NSL)) bus ();
  sprite_line_scheduler #(.MAX_SPRITES(NSPR), .SLOTS(NSL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] obj_mem [0:63];
  always @(posedge clk) bus.obj_rd_data <= obj_mem[bus.obj_rd_addr];

  int n_vec = 0;
  int n_err = 0;
  bit exp_ovf, exp_late;
  logic [NSL-1:0]   last_v;
  logic [4*NSL-1:0] last_idx, last_row;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: walk the sprite list in index order, keep the first NSL hits.
  task automatic model(input int ny, output logic [NSL-1:0] v, output logic [4*NSL-1:0] idx,
                       output logic [4*NSL-1:0] row, output bit ovf);
    int n;
    n = 0; v = '0; idx = '0; row = '0; ovf = 0;
    for (int i = 0; i < NSPR; i++) begin
      int y, h;
      y = obj_mem[4*i+1];
      h = (obj_mem[4*i+3] & 15) + 1;
      if (y != 255 && ny >= y && ny < y + h) begin
        if (n < NSL) begin
          idx[4*n +: 4] = 4'(i);
          row[4*n +: 4] = 4'(ny - y);
          v[n] = 1'b1;
          n++;
        end else ovf = 1;
      end
    end
  endtask

  task automatic clear_table();
    for (int i = 0; i < 64; i++) obj_mem[i] = 8'($urandom);
    for (int i = 0; i < NSPR; i++) obj_mem[4*i+1] = 8'hFF;
  endtask

  task automatic set_spr(input int i, input logic [7:0] y, input logic [7:0] size);
    obj_mem[4*i+1] = y;
    obj_mem[4*i+3] = size;
  endtask

  task automatic pulse_frame();
    @(negedge clk) bus.frame_start = 1'b1;
    @(negedge clk) bus.frame_start = 1'b0;
    exp_ovf = 0; exp_late = 0;
  endtask

  // Leaves the caller at the negedge of cycle 1 after the sampling edge.
  task automatic pulse_line(input logic [7:0] ny);
    @(negedge clk);
    bus.next_y = ny; bus.line_start = 1'b1;
    @(negedge clk) bus.line_start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!bus.done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_result(input string tag, input logic [7:0] ny, input int cyc);
    logic [NSL-1:0] v; logic [4*NSL-1:0] idx, row; bit ovf;
    model(ny, v, idx, row, ovf);
    if (ovf) exp_ovf = 1;
    check_eq({tag, " latency"}, cyc, LAT);
    check_eq({tag, " slot_valid"}, bus.slot_valid, v);
    check_eq({tag, " slot_idx"}, bus.slot_idx & {{NSL{4'b0}}, 4'b0} | (bus.slot_idx & idx_mask(v)), idx);
    check_eq({tag, " slot_row"}, bus.slot_row & idx_mask(v), row);
    check_eq({tag, " overflow"}, bus.overflow, exp_ovf);
    check_eq({tag, " late"}, bus.late, exp_late);
    last_v = v; last_idx = bus.slot_idx; last_row = bus.slot_row;
    @(negedge clk);
    check_eq({tag, " done width"}, bus.done, 1'b0);
  endtask

  function automatic logic [4*NSL-1:0] idx_mask(input logic [NSL-1:0] v);
    logic [4*NSL-1:0] m;
    m = '0;
    for (int i = 0; i < NSL; i++) if (v[i]) m[4*i +: 4] = 4'hF;
    return m;
  endfunction

  task automatic run_line(input string tag, input logic [7:0] ny);
    int cyc;
    pulse_line(ny);
    wait_done(cyc);
    check_result(tag, ny, cyc);
  endtask

  task automatic check_idle_zero(input string tag);
    check_eq({tag, " slot_valid"}, bus.slot_valid, 0);
    check_eq({tag, " slot_idx"}, bus.slot_idx, 0);
    check_eq({tag, " slot_row"}, bus.slot_row, 0);
    check_eq({tag, " busy"}, bus.busy, 0);
    check_eq({tag, " done"}, bus.done, 0);
    check_eq({tag, " overflow"}, bus.overflow, 0);
    check_eq({tag, " late"}, bus.late, 0);
    check_eq({tag, " addr"}, bus.obj_rd_addr, 0);
  endtask

  initial begin
    int cyc, pulses;
    rst_n = 1'b0;
    bus.enable = 1'b0; bus.frame_start = 1'b0; bus.line_start = 1'b0; bus.next_y = '0;
    exp_ovf = 0; exp_late = 0;
    clear_table();
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    rst_n = 1'b1;
    bus.enable = 1'b1;

    // single hit, h=4
    set_spr(2, 8'd10, 8'h33);
    run_line("single", 8'd12);
    check_eq("single idx0", bus.slot_idx[3:0], 4'd2);
    check_eq("single row0", bus.slot_row[3:0], 4'd2);

    // six sprites on one line: overflow, then frame_start clears it
    clear_table();
    for (int i = 0; i < 6; i++) set_spr(i, 8'd20, 8'h00);
    run_line("ovf", 8'd20);
    check_eq("ovf flag", bus.overflow, 1'b1);
    pulse_frame();
    check_eq("ovf cleared", bus.overflow, 1'b0);

    // bottom-of-range sprite, no wrap, disabled entry
    clear_table();
    set_spr(0, 8'd250, 8'h0F);
    set_spr(5, 8'hFF, 8'h0F);
    run_line("edge255", 8'd255);
    check_eq("edge255 row", bus.slot_row[3:0], 4'd5);
    run_line("nowrap", 8'd4);
    check_eq("nowrap valid", bus.slot_valid, 0);

    // random tables and lines
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < 64; i++) obj_mem[i] = 8'($urandom);
      for (int i = 0; i < NSPR; i++)
        obj_mem[4*i+1] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 40));
      if ($urandom_range(0, 3) == 0) pulse_frame();
      run_line("rand", 8'($urandom_range(0, 50)));
    end

    // restart while busy
    pulse_frame();
    clear_table();
    set_spr(1, 8'd30, 8'h01);
    set_spr(4, 8'd40, 8'h07);
    pulse_line(8'd30);
    repeat (9) begin
      @(negedge clk);
      if (bus.done) check_eq("late early done", bus.done, 1'b0);
    end
    bus.next_y = 8'd43; bus.line_start = 1'b1;
    @(negedge clk) bus.line_start = 1'b0;
    exp_late = 1;
    wait_done(cyc);
    check_result("late", 8'd43, cyc);
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    check_eq("late extra done", pulses, 0);

    // enable dropped mid-scan
    set_spr(4, 8'd40, 8'h00);
    pulse_line(8'd40);
    repeat (8) @(negedge clk);
    bus.enable = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    check_eq("abort done", pulses, 0);
    check_eq("abort busy", bus.busy, 0);
    check_eq("abort valid", bus.slot_valid, last_v);
    check_eq("abort idx", bus.slot_idx, last_idx);
    check_eq("abort row", bus.slot_row, last_row);
    bus.enable = 1'b1;
    run_line("resume", 8'd40);

    // reset during EVAL of sprite 0
    pulse_line(8'd40);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle_zero("rst_eval");
    rst_n = 1'b1;
    exp_ovf = 0; exp_late = 0;
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    check_eq("rst_eval done", pulses, 0);
    run_line("after_rst", 8'd40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
